// File: rtl/sdf_bf_stage_if.sv
// Sample stream bundle for one radix-2^2 SDF butterfly stage: input sample
// with its valid strobe, registered output sample with its valid strobe, and
// the sticky saturation flag.
interface sdf_bf_stage_if #(
    parameter int WIDTH = 16
);
    logic                    di_en;
    logic signed [WIDTH-1:0] di_re;
    logic signed [WIDTH-1:0] di_im;
    logic                    do_en;
    logic signed [WIDTH-1:0] do_re;
    logic signed [WIDTH-1:0] do_im;
    logic                    ovf;

    // Sample source / sink side (testbench or upstream logic).
    modport master (
        output di_en, di_re, di_im,
        input  do_en, do_re, do_im, ovf
    );

    // Butterfly stage side.
    modport slave (
        input  di_en, di_re, di_im,
        output do_en, do_re, do_im, ovf
    );
endinterface

// File: rtl/sdf_bf_stage.sv
// One radix-2^2 single-path delay-feedback butterfly stage. A D-entry delay
// line holds the first half of each 2D-sample block. During the second half
// the stage emits the butterfly sums and feeds the differences back into the
// delay line, and those differences drain out during the next first half.
// The trivial -j twiddle is optionally applied in the upper-half blocks.
module sdf_bf_stage #(
    parameter int WIDTH = 16,
    parameter int DLOG2 = 4,
    parameter int SCALE = 1,
    parameter int MJ_EN = 0
) (
    input  logic           clock,
    input  logic           reset,
    sdf_bf_stage_if.slave  bus
);
    localparam int D  = 1 << DLOG2;
    localparam int CW = DLOG2 + 2;

    typedef logic signed [WIDTH-1:0] smp_t;
    typedef logic signed [WIDTH:0]   wide_t;

    localparam smp_t S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam smp_t S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Butterfly output shaping: rounded halving, or clamping to the sample range.
    function automatic smp_t shape(input wide_t v);
        wide_t r;
        r = v + wide_t'(1);
        if (SCALE != 0)
            return r[WIDTH:1];
        else if (v[WIDTH] != v[WIDTH-1])
            return v[WIDTH] ? S_MIN : S_MAX;
        else
            return v[WIDTH-1:0];
    endfunction

    // True when shape() had to clamp v.
    function automatic logic clips(input wide_t v);
        return (SCALE == 0) && (v[WIDTH] != v[WIDTH-1]);
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic          primed_q, primed_d;
    logic          ovf_q, ovf_d;
    logic          do_en_q, do_en_d;
    smp_t          do_re_q, do_re_d;
    smp_t          do_im_q, do_im_d;
    smp_t          dl_re_q [D];
    smp_t          dl_im_q [D];
    smp_t          dl_in_re, dl_in_im;

    logic  bf_en, mj, neg_sat;
    smp_t  neg_re, x0_re, x0_im, x1_re, x1_im;
    wide_t add_re, add_im, sub_re, sub_im;

    assign bf_en = cnt_q[DLOG2];
    assign mj    = (MJ_EN != 0) && cnt_q[DLOG2+1] && cnt_q[DLOG2];
    assign x0_re = dl_re_q[D-1];
    assign x0_im = dl_im_q[D-1];

    // Optional -j rotation of the incoming sample, with saturated negation.
    always_comb begin
        neg_sat = (bus.di_re == S_MIN);
        neg_re  = neg_sat ? S_MAX : -bus.di_re;
        if (mj) begin
            x1_re = bus.di_im;
            x1_im = neg_re;
        end else begin
            x1_re = bus.di_re;
            x1_im = bus.di_im;
        end
        add_re = {x0_re[WIDTH-1], x0_re} + {x1_re[WIDTH-1], x1_re};
        add_im = {x0_im[WIDTH-1], x0_im} + {x1_im[WIDTH-1], x1_im};
        sub_re = {x0_re[WIDTH-1], x0_re} - {x1_re[WIDTH-1], x1_re};
        sub_im = {x0_im[WIDTH-1], x0_im} - {x1_im[WIDTH-1], x1_im};
    end

    // Next-state: counter, priming, overflow, output sample and delay-line input.
    always_comb begin
        // NOTE: every output of this block is defaulted first so that no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        cnt_d    = cnt_q;
        primed_d = primed_q;
        ovf_d    = ovf_q;
        do_en_d  = 1'b0;
        do_re_d  = do_re_q;
        do_im_d  = do_im_q;
        dl_in_re = x1_re;
        dl_in_im = x1_im;
        if (bus.di_en) begin
            cnt_d   = cnt_q + 1'b1;
            do_en_d = bf_en | primed_q;
            if (bf_en) begin
                primed_d = 1'b1;
                do_re_d  = shape(add_re);
                do_im_d  = shape(add_im);
                dl_in_re = shape(sub_re);
                dl_in_im = shape(sub_im);
                if (clips(add_re) || clips(add_im) || clips(sub_re) || clips(sub_im))
                    ovf_d = 1'b1;
            end else begin
                do_re_d = x0_re;
                do_im_d = x0_im;
            end
            if (mj && neg_sat)
                ovf_d = 1'b1;
        end
    end

    // State registers and delay line; reset wins over di_en.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            ovf_q    <= 1'b0;
            do_en_q  <= 1'b0;
            do_re_q  <= '0;
            do_im_q  <= '0;
            // NOTE: the delay line is cleared on reset on purpose: a reset
            // mid-frame must discard partial data, not leak it into the next frame.
            for (int i = 0; i < D; i++) begin
                dl_re_q[i] <= '0;
                dl_im_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            ovf_q    <= ovf_d;
            do_en_q  <= do_en_d;
            do_re_q  <= do_re_d;
            do_im_q  <= do_im_d;
            if (bus.di_en) begin
                dl_re_q[0] <= dl_in_re;
                dl_im_q[0] <= dl_in_im;
                for (int i = 1; i < D; i++) begin
                    dl_re_q[i] <= dl_re_q[i-1];
                    dl_im_q[i] <= dl_im_q[i-1];
                end
            end
        end
    end

    assign bus.do_en = do_en_q;
    assign bus.do_re = do_re_q;
    assign bus.do_im = do_im_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_sdf_bf_stage.sv
// Directed bench for sdf_bf_stage. Three instances share one input stream:
//   u_a: DLOG2=1, SCALE=1            (ordering, rounding, gapped input)
//   u_b: DLOG2=0, SCALE=0, MJ_EN=1   (saturation, -j rotation, sticky ovf)
//   u_c: DLOG2=2, SCALE=1            (reset mid-frame)
// Expected values are worked out by hand in the comments beside each step.
module tb_sdf_bf_stage;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic        di_en = 1'b0;
    logic [15:0] di_re = '0;
    logic [15:0] di_im = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sdf_bf_stage_if #(.WIDTH(16)) if_a ();
    sdf_bf_stage_if #(.WIDTH(16)) if_b ();
    sdf_bf_stage_if #(.WIDTH(16)) if_c ();

    assign if_a.di_en = di_en;
    assign if_a.di_re = di_re;
    assign if_a.di_im = di_im;
    assign if_b.di_en = di_en;
    assign if_b.di_re = di_re;
    assign if_b.di_im = di_im;
    assign if_c.di_en = di_en;
    assign if_c.di_re = di_re;
    assign if_c.di_im = di_im;

    sdf_bf_stage #(.WIDTH(16), .DLOG2(1), .SCALE(1), .MJ_EN(0)) u_a (
        .clock(clock), .reset(reset), .bus(if_a.slave));
    sdf_bf_stage #(.WIDTH(16), .DLOG2(0), .SCALE(0), .MJ_EN(1)) u_b (
        .clock(clock), .reset(reset), .bus(if_b.slave));
    sdf_bf_stage #(.WIDTH(16), .DLOG2(2), .SCALE(1), .MJ_EN(0)) u_c (
        .clock(clock), .reset(reset), .bus(if_c.slave));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one input, clock it in, and settle just after the edge.
    task automatic cyc(input logic en, input logic [15:0] re, input logic [15:0] im);
        di_en = en;
        di_re = re;
        di_im = im;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 16'h0, 16'h0);
        reset = 1'b0;
    endtask

    // Gapless reference for u_a: inputs 4,6,2,2,0,0 -> do_en / do_re per input.
    logic [15:0] gap_in [6]  = '{16'd4, 16'd6, 16'd2, 16'd2, 16'd0, 16'd0};
    logic        gap_en [6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] gap_re [6]  = '{16'd0, 16'd0, 16'd3, 16'd4, 16'd1, 16'd2};

    initial begin
        cyc(1'b0, 16'h0, 16'h0);
        cyc(1'b0, 16'h0, 16'h0);
        reset = 1'b0;

        // ---- reset state ----
        check("rst_a_en",  {15'd0, if_a.do_en}, 16'd0);
        check("rst_a_re",  if_a.do_re, 16'd0);
        check("rst_b_ovf", {15'd0, if_b.ovf}, 16'd0);
        check("rst_c_im",  if_c.do_im, 16'd0);

        // ---- u_a gapless: 4,6 | 2,2 -> sums 3,4 ; then diffs 1,2 ----
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, gap_in[i], 16'h0);
            check($sformatf("a_en%0d", i), {15'd0, if_a.do_en}, {15'd0, gap_en[i]});
            check($sformatf("a_re%0d", i), if_a.do_re, gap_re[i]);
        end
        // Next half-block against zero delay line: (-3,5),(-1,-2)
        // sums: (-2>>>1, 6>>1) = (-1,3); (0>>1, -1>>>1) = (0,-1)
        cyc(1'b1, 16'hFFFD, 16'd5);
        check("a_rnd_re0", if_a.do_re, 16'hFFFF);
        check("a_rnd_im0", if_a.do_im, 16'd3);
        cyc(1'b1, 16'hFFFF, 16'hFFFE);
        check("a_rnd_re1", if_a.do_re, 16'd0);
        check("a_rnd_im1", if_a.do_im, 16'hFFFF);
        // diffs: (3,-5) -> (2,-2); (1,2) -> (1,1)
        cyc(1'b1, 16'h0, 16'h0);
        check("a_dif_re0", if_a.do_re, 16'd2);
        check("a_dif_im0", if_a.do_im, 16'hFFFE);
        cyc(1'b1, 16'h0, 16'h0);
        check("a_dif_re1", if_a.do_re, 16'd1);
        check("a_dif_im1", if_a.do_im, 16'd1);

        // ---- u_a gapped: same stream with idle cycles interleaved ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, gap_in[i], 16'h0);
            check($sformatf("g_en%0d", i), {15'd0, if_a.do_en}, {15'd0, gap_en[i]});
            check($sformatf("g_re%0d", i), if_a.do_re, gap_re[i]);
            cyc(1'b0, 16'h5555, 16'h1234);
            check($sformatf("g_idle_en%0d", i), {15'd0, if_a.do_en}, 16'd0);
            check($sformatf("g_idle_re%0d", i), if_a.do_re, gap_re[i]);
        end

        // ---- u_b -j rotation: (1,0),(0,0),(0,0),(0,2),(0,0) ----
        do_reset();
        cyc(1'b1, 16'd1, 16'd0);
        check("b_rot_en0", {15'd0, if_b.do_en}, 16'd0);
        cyc(1'b1, 16'd0, 16'd0);            // sum (1,0), diff (1,0) stored
        check("b_rot_en1", {15'd0, if_b.do_en}, 16'd1);
        check("b_rot_re1", if_b.do_re, 16'd1);
        cyc(1'b1, 16'd0, 16'd0);            // drains diff (1,0)
        check("b_rot_re2", if_b.do_re, 16'd1);
        cyc(1'b1, 16'd0, 16'd2);            // x1 -> (2,0); sum (2,0)
        check("b_rot_re3", if_b.do_re, 16'd2);
        check("b_rot_im3", if_b.do_im, 16'd0);
        cyc(1'b1, 16'd0, 16'd0);            // drains diff (-2,0)
        check("b_rot_re4", if_b.do_re, 16'hFFFE);
        check("b_rot_im4", if_b.do_im, 16'd0);
        check("b_rot_ovf", {15'd0, if_b.ovf}, 16'd0);

        // ---- u_b min-value negation: continue at cnt=1 ----
        cyc(1'b1, 16'd0, 16'd0);
        cyc(1'b1, 16'd0, 16'd0);
        check("b_neg_ovf_pre", {15'd0, if_b.ovf}, 16'd0);
        cyc(1'b1, 16'h8000, 16'd0);         // mj: x1 = (0, 0x7FFF)
        check("b_neg_im", if_b.do_im, 16'h7FFF);
        check("b_neg_re", if_b.do_re, 16'd0);
        check("b_neg_ovf", {15'd0, if_b.ovf}, 16'd1);

        // ---- u_b positive saturation and sticky ovf ----
        do_reset();
        check("b_ovf_clr", {15'd0, if_b.ovf}, 16'd0);
        cyc(1'b1, 16'h7FFF, 16'd0);
        cyc(1'b1, 16'h0001, 16'd0);         // 0x8000 clamps to 0x7FFF
        check("b_sat_re", if_b.do_re, 16'h7FFF);
        check("b_sat_ovf", {15'd0, if_b.ovf}, 16'd1);
        cyc(1'b1, 16'd0, 16'd0);            // diff 0x7FFE drains
        check("b_sat_dif", if_b.do_re, 16'h7FFE);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'd0, 16'd0);
        check("b_ovf_sticky", {15'd0, if_b.ovf}, 16'd1);
        do_reset();
        check("b_ovf_reset", {15'd0, if_b.ovf}, 16'd0);
        cyc(1'b1, 16'h8000, 16'd0);
        cyc(1'b1, 16'hFFFF, 16'd0);         // -32769 clamps to 0x8000
        check("b_nsat_re", if_b.do_re, 16'h8000);
        check("b_nsat_ovf", {15'd0, if_b.ovf}, 16'd1);

        // ---- u_c reset mid-frame ----
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'd10, 16'd10);
        reset = 1'b1;
        cyc(1'b1, 16'd10, 16'd10);          // reset wins over di_en
        reset = 1'b0;
        check("c_rst_en", {15'd0, if_c.do_en}, 16'd0);
        check("c_rst_re", if_c.do_re, 16'd0);
        check("c_rst_im", if_c.do_im, 16'd0);
        cyc(1'b1, 16'd8, 16'd0);
        cyc(1'b1, 16'd0, 16'd0);
        cyc(1'b1, 16'd0, 16'd0);
        cyc(1'b1, 16'd0, 16'd0);
        check("c_en4", {15'd0, if_c.do_en}, 16'd0);
        cyc(1'b1, 16'd4, 16'd0);            // (8+4+1)>>1 = 6
        check("c_en5", {15'd0, if_c.do_en}, 16'd1);
        check("c_re5", if_c.do_re, 16'd6);
        check("c_im5", if_c.do_im, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
